switch_event_capture: RTL and testbench
=======================================

# switch_event_capture

Bus-attached edge-capture and interrupt block that sits directly downstream of the debounced switch filter in the SoC switch path. It samples the already-debounced switch levels, detects per-bit rising and falling edges, latches enabled edges into a sticky pending register, and raises a level interrupt to the processor. Software accesses level, pending and enable registers over the same 4-way Read/Write/Ready handshake used by the other SoC peripherals.

## Interface

- WIDTH, 8, number of switch bits (1..32)
- clock  in  1  system clock; all state changes on posedge
- reset  in  1  synchronous, active-high reset
- Read  in  1  bus read request; held until Ready seen
- Write  in  1  bus write request; held until Ready seen
- Address  in  2  register select
- DataIn  in  32  write data
- DataOut  out  32  read data, valid while Ready=1 for a read
- Ready  out  1  handshake acknowledge
- Switch_in  in  WIDTH  debounced switch levels from the filter stage
- Interrupt  out  1  high while any pending bit is set

## Operation

- Register map (word index): 0 LEVEL (RO, current Switch_in), 1 PENDING (W1C), 2 RISE_EN (RW), 3 FALL_EN (RW); bits above WIDTH read 0, writes ignored.
- Writes to LEVEL are accepted and ignored.
- Edge detect: prev register holds last-cycle Switch_in; rise = Switch_in & ~prev, fall = ~Switch_in & prev.
- Pending set: pending |= (rise & RISE_EN) | (fall & FALL_EN), every cycle.
- W1C: write to PENDING clears bits where DataIn=1.
- Same-cycle set and clear on one bit: set wins (bit stays 1).
- Changing RISE_EN/FALL_EN never alters PENDING; disabling an edge leaves existing pending bits set.
- Interrupt = OR of PENDING, registered (no mask beyond the enables).
- Handshake: transaction starts on the first cycle Read|Write is high while Ready=0. Side effect (write or read-data capture) executes exactly once, at that start cycle. Ready goes high next cycle and stays high while Read|Write stays high; drops the cycle after both go low. A new transaction requires Ready to have returned to 0.
- Read and Write both high: treated as write; DataOut returns 0.
- Reset: PENDING, RISE_EN, FALL_EN, Ready, Interrupt, DataOut all 0; prev loads Switch_in (no spurious edge on the first cycle after reset). Reset mid-transaction aborts it; Ready=0 next cycle, master must re-issue.

## Timing

- Switch_in edge at cycle N (sampled) -> PENDING bit set visible at N+1 -> Interrupt high at N+2.
- Request start at cycle N -> Ready=1 and DataOut valid at N+1; write effect visible in registers at N+1.
- DataOut is a snapshot from cycle N; held constant until next read start; 0 after a write.
- W1C write at N with no new edge -> Interrupt low at N+2 if no other bits pending.
- Minimum transaction: 2 cycles request-to-Ready, 1 cycle Ready-to-release; back-to-back throughput one access per 3 cycles.

## Structure

- Shared SoC package: register index constants (SW_EVT_LEVEL=0, SW_EVT_PENDING=1, SW_EVT_RISE_EN=2, SW_EVT_FALL_EN=3).
- One sub-module: switch_edge_detect (prev register plus rise/fall vectors, WIDTH-parameterised, reset loads prev from input).
- Top holds registers, handshake state (idle/ack, one flop = Ready) and read mux.

## Test plan

- Reset with Switch_in=8'hA5 -> all outputs 0; hold 3 cycles after reset -> PENDING stays 0, Interrupt 0.
- Write RISE_EN=8'h01, toggle Switch_in bit0 0->1 -> PENDING=8'h01 one cycle later, Interrupt=1 two cycles later; falling edge adds nothing.
- Read PENDING with Read held 5 cycles -> Ready high from cycle 2 through Read release+1, DataOut=32'h01 constant, single side-effect (PENDING unchanged).
- Write PENDING DataIn=32'h01 in the same cycle bit0 rises again (enabled) -> PENDING bit0 remains 1, Interrupt stays 1.
- FALL_EN=8'h80, bit7 falls, then clear FALL_EN -> PENDING=8'h80 retained; W1C 32'h80 -> PENDING=0, Interrupt=0 two cycles later.
- Assert reset during a held write to RISE_EN -> Ready 0 next cycle, RISE_EN=0; re-issued write completes normally.

Source files
------------

// File: rtl/switch_event_capture_pkg.sv
// +--------------------------------------------------------------------------+
// | switch_event_capture_pkg : register map and bus constants shared by the  |
// | switch event capture block.                            Revision: 1.0     |
// +--------------------------------------------------------------------------+
`default_nettype none

package switch_event_capture_pkg;

   localparam int unsigned BUS_W = 32;

   typedef logic [1:0] reg_idx_t;

   localparam reg_idx_t SW_EVT_LEVEL   = 2'd0;
   localparam reg_idx_t SW_EVT_PENDING = 2'd1;
   localparam reg_idx_t SW_EVT_RISE_EN = 2'd2;
   localparam reg_idx_t SW_EVT_FALL_EN = 2'd3;

endpackage

`default_nettype wire

// File: rtl/switch_event_capture_if.sv
// +--------------------------------------------------------------------------+
// | switch_event_capture_if : 4-way Read/Write/Ready peripheral bus.         |
// |                                                        Revision: 1.0     |
// +--------------------------------------------------------------------------+
`default_nettype none

interface switch_event_capture_if;
   import switch_event_capture_pkg::*;

   logic             Read;
   logic             Write;
   reg_idx_t         Address;
   logic [BUS_W-1:0] DataIn;
   logic [BUS_W-1:0] DataOut;
   logic             Ready;

   modport master (
      output Read,
      output Write,
      output Address,
      output DataIn,
      input  DataOut,
      input  Ready
   );

   modport slave (
      input  Read,
      input  Write,
      input  Address,
      input  DataIn,
      output DataOut,
      output Ready
   );

endinterface

`default_nettype wire

// File: rtl/switch_event_capture_edge_detect.sv
// +--------------------------------------------------------------------------+
// | switch_edge_detect : per-bit rising/falling edge detector on the        |
// | debounced switch levels.                               Revision: 1.0     |
// +--------------------------------------------------------------------------+
`default_nettype none

module switch_edge_detect #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic [WIDTH-1:0] level_i,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o
);

   logic [WIDTH-1:0] prev_q;

   // prev always follows the input, so during reset it is already loaded with
   // the live level and the first cycle after reset sees no spurious edge.
   always_ff @(posedge clock) begin
      prev_q <= level_i;
   end

   assign rise_o = level_i & ~prev_q;
   assign fall_o = ~level_i & prev_q;

endmodule

`default_nettype wire

// File: rtl/switch_event_capture.sv
// +--------------------------------------------------------------------------+
// | switch_event_capture : edge capture, sticky pending and interrupt with  |
// | a Read/Write/Ready register interface.                 Revision: 1.0     |
// +--------------------------------------------------------------------------+
`default_nettype none

module switch_event_capture
   import switch_event_capture_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   switch_event_capture_if.slave  bus,
   input  logic [WIDTH-1:0]       Switch_in,
   output logic                   Interrupt
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_ACK  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic [WIDTH-1:0] rise_en_q, rise_en_d;
   logic [WIDTH-1:0] fall_en_q, fall_en_d;
   logic [BUS_W-1:0] dataout_q, dataout_d;
   logic             interrupt_q;

   logic [WIDTH-1:0] rise_w, fall_w, set_w, clr_w;
   logic [BUS_W-1:0] rdata_w;
   logic             req_w, start_w, wr_start_w, rd_start_w;

   switch_edge_detect #(.WIDTH(WIDTH)) u_edge (
      .clock   (clock),
      .level_i (Switch_in),
      .rise_o  (rise_w),
      .fall_o  (fall_w)
   );

   generate
      if (WIDTH < BUS_W) begin : g_unused_din
         logic unused_din_bits;
         assign unused_din_bits = ^bus.DataIn[BUS_W-1:WIDTH];
      end
   endgenerate

   assign req_w      = bus.Read | bus.Write;
   assign start_w    = req_w && (state_q == ST_IDLE);
   assign wr_start_w = start_w && bus.Write;
   assign rd_start_w = start_w && bus.Read && !bus.Write;

   // Handshake state register
   always_ff @(posedge clock) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Handshake next state: ACK is held for as long as the master holds its request
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (req_w)  state_d = ST_ACK;
         ST_ACK:  if (!req_w) state_d = ST_IDLE;
         default:             state_d = ST_IDLE;
      endcase
   end

   // Handshake outputs
   always_comb begin
      bus.Ready = (state_q == ST_ACK);
   end

   always_comb begin
      rdata_w = '0;
      case (bus.Address)
         SW_EVT_LEVEL:   rdata_w[WIDTH-1:0] = Switch_in;
         SW_EVT_PENDING: rdata_w[WIDTH-1:0] = pending_q;
         SW_EVT_RISE_EN: rdata_w[WIDTH-1:0] = rise_en_q;
         SW_EVT_FALL_EN: rdata_w[WIDTH-1:0] = fall_en_q;
         default:        rdata_w = '0;
      endcase
   end

   // Set is OR'd in after the clear so a same-cycle edge keeps its bit pending
   always_comb begin
      set_w     = (rise_w & rise_en_q) | (fall_w & fall_en_q);
      clr_w     = '0;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      dataout_d = dataout_q;
      if (wr_start_w) begin
         dataout_d = '0;
         case (bus.Address)
            SW_EVT_PENDING: clr_w     = bus.DataIn[WIDTH-1:0];
            SW_EVT_RISE_EN: rise_en_d = bus.DataIn[WIDTH-1:0];
            SW_EVT_FALL_EN: fall_en_d = bus.DataIn[WIDTH-1:0];
            default:        ;
         endcase
      end else if (rd_start_w) begin
         dataout_d = rdata_w;
      end
      pending_d = (pending_q & ~clr_w) | set_w;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pending_q   <= '0;
         rise_en_q   <= '0;
         fall_en_q   <= '0;
         dataout_q   <= '0;
         interrupt_q <= 1'b0;
      end else begin
         pending_q   <= pending_d;
         rise_en_q   <= rise_en_d;
         fall_en_q   <= fall_en_d;
         dataout_q   <= dataout_d;
         interrupt_q <= |pending_q;
      end
   end

   assign bus.DataOut = dataout_q;
   assign Interrupt   = interrupt_q;

endmodule

`default_nettype wire

// File: tb/tb_switch_event_capture.sv
// +--------------------------------------------------------------------------+
// | tb_switch_event_capture : directed and randomized bench for             |
// | switch_event_capture against a behavioural model.      Revision: 1.0     |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_switch_event_capture;

   localparam int W = 8;

   logic         clock;
   logic         reset;
   logic [W-1:0] sw;
   logic         irq;

   int n_checks = 0;
   int n_errors = 0;
   bit rand_sw  = 1'b0;

   // Behavioural model of the programmer-visible state
   bit [W-1:0]  m_pending, m_rise, m_fall, m_prev;
   bit [31:0]   m_dout;
   bit          m_ready, m_int;

   switch_event_capture_if bus_if ();

   switch_event_capture #(.WIDTH(W)) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus_if.slave),
      .Switch_in (sw),
      .Interrupt (irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock of the model, evaluated on the inputs present at the rising edge.
   task automatic model_step();
      bit         req, start;
      bit [W-1:0] set_bits, clr_bits;
      bit [31:0]  rd_val;
      if (reset) begin
         m_pending = '0; m_rise = '0; m_fall = '0;
         m_dout = '0; m_ready = 1'b0; m_int = 1'b0;
         m_prev = sw;
         return;
      end
      req   = bus_if.Read || bus_if.Write;
      start = req && !m_ready;
      m_int = (m_pending != 0);
      set_bits = '0;
      for (int i = 0; i < W; i++) begin
         if (sw[i] && !m_prev[i] && m_rise[i]) set_bits[i] = 1'b1;
         if (!sw[i] && m_prev[i] && m_fall[i]) set_bits[i] = 1'b1;
      end
      clr_bits = '0;
      if (start) begin
         if (bus_if.Write) begin
            m_dout = 0;
            case (bus_if.Address)
               2'd1: clr_bits = bus_if.DataIn[W-1:0];
               2'd2: m_rise   = bus_if.DataIn[W-1:0];
               2'd3: m_fall   = bus_if.DataIn[W-1:0];
               default: ;
            endcase
         end else begin
            case (bus_if.Address)
               2'd0: rd_val = 32'(sw);
               2'd1: rd_val = 32'(m_pending);
               2'd2: rd_val = 32'(m_rise);
               default: rd_val = 32'(m_fall);
            endcase
            m_dout = rd_val;
         end
      end
      m_pending = (m_pending & ~clr_bits) | set_bits;
      m_ready   = start ? 1'b1 : (m_ready && req);
      m_prev    = sw;
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      @(negedge clock);
      check_value("ready", 32'(bus_if.Ready), 32'(m_ready));
      check_value("dataout", bus_if.DataOut, m_dout);
      check_value("interrupt", 32'(irq), 32'(m_int));
      if (rand_sw) sw = W'($urandom);
   endtask

   // Full transaction: request, optional hold after Ready, release, wait for Ready low.
   task automatic bus_access(input bit rd, input bit wr, input logic [1:0] a,
                             input logic [31:0] d, input int hold,
                             input bit chg_sw, input logic [W-1:0] new_sw);
      int cnt;
      bus_if.Read = rd; bus_if.Write = wr; bus_if.Address = a; bus_if.DataIn = d;
      if (chg_sw) sw = new_sw;
      cnt = 0;
      do begin tick(); cnt++; end while (!bus_if.Ready && cnt < 8);
      if (!bus_if.Ready) check_value("ready_timeout", 32'(bus_if.Ready), 32'd1);
      repeat (hold) tick();
      bus_if.Read = 1'b0; bus_if.Write = 1'b0;
      cnt = 0;
      do begin tick(); cnt++; end while (bus_if.Ready && cnt < 8);
      if (bus_if.Ready) check_value("release_timeout", 32'(bus_if.Ready), 32'd0);
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
      bus_access(1'b0, 1'b1, a, d, 0, 1'b0, sw);
   endtask

   task automatic rd_reg(input logic [1:0] a, input string tag, input logic [31:0] exp);
      bus_access(1'b1, 1'b0, a, 32'd0, 0, 1'b0, sw);
      check_value(tag, bus_if.DataOut, exp);
   endtask

   initial begin
      bus_if.Read = 1'b0; bus_if.Write = 1'b0; bus_if.Address = 2'd0; bus_if.DataIn = '0;
      sw = 8'hA5;
      reset = 1'b1;
      @(negedge clock);
      tick(); tick();
      check_value("rst_ready", 32'(bus_if.Ready), 32'd0);
      check_value("rst_dout", bus_if.DataOut, 32'd0);
      check_value("rst_irq", 32'(irq), 32'd0);
      reset = 1'b0;
      repeat (3) tick();
      check_value("post_rst_irq", 32'(irq), 32'd0);
      rd_reg(2'd1, "post_rst_pending", 32'd0);
      rd_reg(2'd0, "level", 32'h0000_00A5);

      // Rising edge on bit0 with RISE_EN bit0
      wr_reg(2'd2, 32'h01);
      sw = 8'hA4; tick(); tick();
      sw = 8'hA5; tick();
      check_value("rise_irq_n1", 32'(irq), 32'd0);
      tick();
      check_value("rise_irq_n2", 32'(irq), 32'd1);
      sw = 8'hA4; repeat (2) tick();
      rd_reg(2'd1, "rise_pending", 32'h01);

      // Long read: single side effect, constant data
      bus_access(1'b1, 1'b0, 2'd1, 32'd0, 5, 1'b0, sw);
      check_value("long_read", bus_if.DataOut, 32'h01);

      // W1C coinciding with a new enabled rising edge: set wins
      bus_access(1'b0, 1'b1, 2'd1, 32'h01, 0, 1'b1, 8'hA5);
      check_value("set_wins_irq", 32'(irq), 32'd1);
      rd_reg(2'd1, "set_wins_pending", 32'h01);
      wr_reg(2'd1, 32'h01);
      rd_reg(2'd1, "w1c_pending", 32'h00);

      // Falling edge on bit7, then disable: pending survives
      wr_reg(2'd3, 32'h80);
      sw = 8'h25; repeat (2) tick();
      wr_reg(2'd3, 32'h00);
      rd_reg(2'd1, "fall_pending", 32'h80);
      rd_reg(2'd3, "fall_en_cleared", 32'h00);
      wr_reg(2'd1, 32'h80);
      tick();
      check_value("fall_clear_irq", 32'(irq), 32'd0);
      rd_reg(2'd1, "fall_clear_pending", 32'h00);

      // Read and Write together acts as a write and returns 0
      bus_access(1'b1, 1'b1, 2'd2, 32'h3C, 0, 1'b0, sw);
      check_value("rw_dout", bus_if.DataOut, 32'd0);
      rd_reg(2'd2, "rw_rise_en", 32'h3C);
      wr_reg(2'd2, 32'h00);

      // Reset in the middle of a held write
      bus_if.Write = 1'b1; bus_if.Address = 2'd2; bus_if.DataIn = 32'hFF;
      tick(); tick();
      reset = 1'b1;
      tick();
      check_value("abort_ready", 32'(bus_if.Ready), 32'd0);
      bus_if.Write = 1'b0; reset = 1'b0;
      tick();
      rd_reg(2'd2, "abort_rise_en", 32'h00);
      wr_reg(2'd2, 32'hFF);
      rd_reg(2'd2, "reissue_rise_en", 32'hFF);

      // Randomized traffic with toggling switches and occasional resets
      rand_sw = 1'b1;
      for (int it = 0; it < 150; it++) begin
         logic       rd, wr;
         logic [1:0] a;
         logic [31:0] d;
         if ($urandom_range(0, 19) == 0) begin
            reset = 1'b1; tick(); reset = 1'b0;
         end
         wr = ($urandom_range(0, 1) == 1);
         rd = !wr || ($urandom_range(0, 3) == 0);
         a  = 2'($urandom);
         d  = $urandom;
         bus_access(rd, wr, a, d, int'($urandom_range(0, 3)), 1'b0, sw);
         repeat ($urandom_range(0, 2)) tick();
      end
      rand_sw = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

`default_nettype wire
